beat_sequencer: RTL and testbench

Record/playback controller for the tone generator.
- Record: samples the live key code on a fixed tick and run-length encodes it into (code, duration) events in a small on-chip memory.
- Playback: replays the stored events by driving the 7-bit key code that the rate divider converts to a buzzer frequency.
- Placement: between the keyboard decoder and the tone generator; the tone generator itself is unchanged.

---
 rtl/beat_pkg.sv | 20 ++
 rtl/beat_event_ram.sv | 24 ++
 rtl/beat_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_beat_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// Shared types and constants for the record/playback beat sequencer.
package beat_pkg;

  localparam int CODE_W = 7;
  localparam logic [CODE_W-1:0] NO_KEY = 7'd0;

  // Controller states: idle monitor, recording, playback load, playback run.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REC   = 2'd1,
    S_PLOAD = 2'd2,
    S_PRUN  = 2'd3
  } state_e;

  // Address width for a memory of the given depth (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/beat_event_ram.sv
// Event storage: one write port, one synchronous read port (1-cycle latency).
module beat_event_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 23,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write on request; read address is registered every cycle.
  // NOTE: the array has no reset; the stored event count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/beat_sequencer.sv
// Record/playback controller: run-length encodes the live key code on a fixed
// tick into (code, duration) events and replays them onto note_out.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DEPTH    = 64,
  parameter int DUR_W    = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [6:0]                 ascii_in,
  input  logic                       rec_start,
  input  logic                       play_start,
  input  logic                       stop,
  input  logic                       loop_en,
  output logic [6:0]                 note_out,
  output logic                       busy_rec,
  output logic                       busy_play,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       done
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = addr_w(DEPTH);
  localparam int PW    = $clog2(TICK_DIV + 1);
  localparam int EVT_W = CODE_W + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [DUR_W-1:0]  dur;
  } event_t;

  state_e              state_q, state_d;
  logic                phase_q, phase_d;     // PLOAD: 0 = read issued, 1 = data valid
  logic [CODE_W-1:0]   note_q, note_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CODE_W-1:0]   cur_code_q, cur_code_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DUR_W-1:0]    remaining_q, remaining_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                done_q, done_d;
  logic                busy_rec_q, busy_play_q, full_q;

  logic                presc_clr;
  logic                tick;
  logic                we;
  logic [EVT_W-1:0]    rd_data;
  event_t              rd_evt;
  event_t              wr_evt;

  assign tick   = (state_q != S_IDLE) && (presc_q == PW'(TICK_DIV - 1));
  assign wr_evt = '{code: cur_code_q, dur: dur_q};
  assign rd_evt = event_t'(rd_data);

  beat_event_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (count_q[AW-1:0]),
    .wdata (wr_evt),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Next-state, event encoding and playback sequencing.
  always_comb begin
    // NOTE: every value driven here gets a default first, so no path leaves a latch behind.
    state_d     = state_q;
    phase_d     = 1'b0;
    note_d      = note_q;
    count_d     = count_q;
    cur_code_d  = cur_code_q;
    dur_d       = dur_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    we          = 1'b0;
    presc_clr   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        note_d = ascii_in;
        if (stop) begin
          // Nothing to end; stop also masks any start pulse this cycle.
        end else if (play_start) begin
          if (count_q != '0) begin
            state_d   = S_PLOAD;
            rd_ptr_d  = '0;
            presc_clr = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else if (rec_start) begin
          state_d    = S_REC;
          count_d    = '0;
          cur_code_d = ascii_in;
          dur_d      = '0;
          presc_clr  = 1'b1;
        end
      end

      S_REC: begin
        note_d = ascii_in;
        if (stop) begin
          if ((dur_q != '0) && (count_q != CNT_W'(DEPTH))) begin
            we      = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          if ((ascii_in == cur_code_q) && (dur_q != DUR_MAX)) begin
            dur_d = dur_q + DUR_W'(1);
          end else begin
            if (dur_q != '0) begin
              we      = 1'b1;
              count_d = count_q + CNT_W'(1);
              if (count_q == CNT_W'(DEPTH - 1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
            cur_code_d = ascii_in;
            dur_d      = DUR_W'(1);
          end
        end
      end

      S_PLOAD: begin
        // Hold the prescaler so every note starts on a fresh tick period.
        presc_clr = 1'b1;
        if (stop) begin
          note_d  = NO_KEY;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d     = S_PRUN;
          note_d      = rd_evt.code;
          remaining_d = rd_evt.dur;
        end
      end

      S_PRUN: begin
        if (stop) begin
          note_d  = NO_KEY;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          remaining_d = remaining_q - DUR_W'(1);
          if (remaining_q == DUR_W'(1)) begin
            if ((CNT_W'(rd_ptr_q) + CNT_W'(1)) < count_q) begin
              rd_ptr_d = rd_ptr_q + AW'(1);
              state_d  = S_PLOAD;
            end else if (loop_en) begin
              rd_ptr_d = '0;
              state_d  = S_PLOAD;
            end else begin
              note_d  = NO_KEY;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_IDLE) || presc_clr || tick) presc_d = '0;
    else                                          presc_d = presc_q + PW'(1);
  end

  // State and output registers; status flags follow the next state.
  // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      note_q      <= NO_KEY;
      count_q     <= '0;
      cur_code_q  <= NO_KEY;
      dur_q       <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      presc_q     <= '0;
      done_q      <= 1'b0;
      busy_rec_q  <= 1'b0;
      busy_play_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      note_q      <= note_d;
      count_q     <= count_d;
      cur_code_q  <= cur_code_d;
      dur_q       <= dur_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      done_q      <= done_d;
      busy_rec_q  <= (state_d == S_REC);
      busy_play_q <= (state_d == S_PLOAD) || (state_d == S_PRUN);
      full_q      <= (count_d == CNT_W'(DEPTH));
    end
  end

  assign note_out  = note_q;
  assign busy_rec  = busy_rec_q;
  assign busy_play = busy_play_q;
  assign count     = count_q;
  assign full      = full_q;
  assign done      = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer with small parameters.
module tb_beat_sequencer;

  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 4;
  localparam int DUR_W    = 3;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int MAXD     = (1 << DUR_W) - 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [6:0]       ascii_in = '0;
  logic             rec_start = 1'b0;
  logic             play_start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic [6:0]       note_out;
  logic             busy_rec, busy_play, full, done;
  logic [CNT_W-1:0] count;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [6:0] ticks_q[$];
  logic [6:0] exp_code[$];
  int         exp_dur[$];

  typedef struct {
    string      name;
    int         n;
    logic [6:0] codes[10];
    int         exp_count;
    logic       exp_full;
    logic [6:0] ev_code[4];
    int         ev_dur[4];
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  beat_sequencer #(
    .TICK_DIV (TICK_DIV),
    .DEPTH    (DEPTH),
    .DUR_W    (DUR_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ascii_in   (ascii_in),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .loop_en    (loop_en),
    .note_out   (note_out),
    .busy_rec   (busy_rec),
    .busy_play  (busy_play),
    .count      (count),
    .full       (full),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock; sample 1 time unit after the rising edge and tally done pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  // Run-length encoding of the per-tick key codes, capped at DEPTH events.
  function automatic void model_record();
    logic [6:0] cur;
    int run;
    run = 0;
    cur = '0;
    exp_code.delete();
    exp_dur.delete();
    foreach (ticks_q[k]) begin
      if (run > 0 && ticks_q[k] == cur && run < MAXD) begin
        run++;
      end else begin
        if (run > 0) begin
          exp_code.push_back(cur);
          exp_dur.push_back(run);
          if (exp_code.size() == DEPTH) return;
        end
        cur = ticks_q[k];
        run = 1;
      end
    end
    if (run > 0) begin
      exp_code.push_back(cur);
      exp_dur.push_back(run);
    end
  endfunction

  // rec_start, present one code per tick period, then stop.
  task automatic record_ticks();
    ascii_in  = (ticks_q.size() > 0) ? ticks_q[0] : 7'd0;
    done_cnt  = 0;
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    foreach (ticks_q[k]) begin
      ascii_in = ticks_q[k];
      repeat (TICK_DIV) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    ascii_in = 7'd0;
  endtask

  task automatic check_record(input string tag, input int want_count, input logic want_full);
    check({tag, " count"}, 32'(count), 32'(want_count));
    check({tag, " full"}, 32'(full), 32'(want_full));
    check({tag, " busy_rec after"}, 32'(busy_rec), 32'd0);
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
  endtask

  // Expected per-cycle {busy_play, done, note_out} from play_start onward:
  // 2 gap cycles, then each event for dur*TICK_DIV cycles plus the 2-cycle
  // load hold before the next one, then note 0 with done and busy dropped.
  task automatic play_and_check(input string tag);
    logic [8:0] stream[$];
    int last;
    last = exp_code.size() - 1;
    stream.push_back({2'b10, 7'd0});
    stream.push_back({2'b10, 7'd0});
    for (int i = 0; i <= last; i++) begin
      int reps;
      reps = exp_dur[i] * TICK_DIV + ((i < last) ? 2 : 0);
      repeat (reps) stream.push_back({2'b10, exp_code[i]});
    end
    stream.push_back({2'b01, 7'd0});
    ascii_in   = 7'd0;
    loop_en    = 1'b0;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    for (int s = 0; s < stream.size(); s++) begin
      check($sformatf("%s play[%0d] {busy,done,note}", tag, s),
            32'({busy_play, done, note_out}), 32'(stream[s]));
      if (s < stream.size() - 1) step();
    end
  endtask

  initial begin
    logic [6:0] pool[4];
    logic [6:0] prev;
    pool = '{7'd0, 7'd65, 7'd83, 7'd97};

    // Reset values.
    resetn = 1'b0;
    repeat (2) step();
    check("reset note_out", 32'(note_out), 32'd0);
    check("reset busy_rec", 32'(busy_rec), 32'd0);
    check("reset busy_play", 32'(busy_play), 32'd0);
    check("reset count", 32'(count), 32'd0);
    check("reset full", 32'(full), 32'd0);
    check("reset done", 32'(done), 32'd0);
    resetn = 1'b1;
    step();

    // Idle live monitor: one-cycle latency.
    ascii_in = 7'd97;
    step();
    check("idle monitor", 32'(note_out), 32'd97);
    ascii_in = 7'd0;
    step();

    // Playback with nothing stored: done only.
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check("empty play done", 32'(done), 32'd1);
    check("empty play busy", 32'(busy_play), 32'd0);
    step();
    check("empty play done once", 32'(done), 32'd0);

    // Directed record/playback vectors.
    vecs[0].name = "rec65x3_83x2";
    vecs[0].n = 5;
    vecs[0].codes = '{7'd65, 7'd65, 7'd65, 7'd83, 7'd83, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
    vecs[0].exp_count = 2;
    vecs[0].exp_full = 1'b0;
    vecs[0].ev_code = '{7'd65, 7'd83, 7'd0, 7'd0};
    vecs[0].ev_dur = '{3, 2, 0, 0};

    vecs[1].name = "saturate65x9";
    vecs[1].n = 9;
    vecs[1].codes = '{7'd65, 7'd65, 7'd65, 7'd65, 7'd65, 7'd65, 7'd65, 7'd65, 7'd65, 7'd0};
    vecs[1].exp_count = 2;
    vecs[1].exp_full = 1'b0;
    vecs[1].ev_code = '{7'd65, 7'd65, 7'd0, 7'd0};
    vecs[1].ev_dur = '{7, 2, 0, 0};

    vecs[2].name = "full_alternate";
    vecs[2].n = 5;
    vecs[2].codes = '{7'd65, 7'd83, 7'd65, 7'd83, 7'd65, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
    vecs[2].exp_count = 4;
    vecs[2].exp_full = 1'b1;
    vecs[2].ev_code = '{7'd65, 7'd83, 7'd65, 7'd83};
    vecs[2].ev_dur = '{1, 1, 1, 1};

    for (int v = 0; v < 3; v++) begin
      ticks_q.delete();
      for (int k = 0; k < vecs[v].n; k++) ticks_q.push_back(vecs[v].codes[k]);
      record_ticks();
      check_record(vecs[v].name, vecs[v].exp_count, vecs[v].exp_full);
      exp_code.delete();
      exp_dur.delete();
      for (int e = 0; e < vecs[v].exp_count; e++) begin
        exp_code.push_back(vecs[v].ev_code[e]);
        exp_dur.push_back(vecs[v].ev_dur[e]);
      end
      play_and_check(vecs[v].name);
      step();
    end

    // After an auto-stop on full, a later stop pulse is ignored.
    done_cnt = 0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    check("stop after full ignored", 32'(done_cnt), 32'd0);
    check("count kept after full", 32'(count), 32'd4);

    // Loop playback, then stop mid-note.
    ticks_q = '{7'd65, 7'd65, 7'd65, 7'd83, 7'd83};
    record_ticks();
    loop_en    = 1'b1;
    done_cnt   = 0;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    // Sample index 30 lands inside the replayed first event (indices 26..39).
    repeat (30) step();
    check("loop replays 65", 32'(note_out), 32'd65);
    check("loop busy_play", 32'(busy_play), 32'd1);
    check("loop no done", 32'(done_cnt), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loop stop note", 32'(note_out), 32'd0);
    check("loop stop busy", 32'(busy_play), 32'd0);
    check("loop stop done", 32'(done), 32'd1);
    check("loop stop count", 32'(count), 32'd2);
    loop_en = 1'b0;
    step();

    // Reset asserted in the middle of a recording.
    ascii_in  = 7'd65;
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    repeat (6) step();
    check("pre-reset busy_rec", 32'(busy_rec), 32'd1);
    check("pre-reset note", 32'(note_out), 32'd65);
    resetn = 1'b0;
    #1;
    check("mid-rec reset note", 32'(note_out), 32'd0);
    check("mid-rec reset busy_rec", 32'(busy_rec), 32'd0);
    check("mid-rec reset count", 32'(count), 32'd0);
    check("mid-rec reset full", 32'(full), 32'd0);
    step();
    resetn   = 1'b1;
    ascii_in = 7'd0;
    step();

    // Randomized recordings checked against the run-length model.
    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(1, 10);
      ticks_q.delete();
      prev = pool[$urandom_range(0, 3)];
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) prev = pool[$urandom_range(0, 3)];
        ticks_q.push_back(prev);
      end
      model_record();
      record_ticks();
      check_record($sformatf("rand%0d", r), exp_code.size(), exp_code.size() == DEPTH);
      play_and_check($sformatf("rand%0d", r));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
